mem_wb_pipe_reg: RTL and testbench

Parametrised MEM/WB pipeline register for the five-stage datapath, sitting between data memory and the register-file write port. Carries load data, ALU result, destination register and WB control bits with a valid/ready handshake, synchronous flush, and a registered writeback-data mux. It replaces the fixed-width, always-load stage register and adds stall, bubble and flush support.

---
 rtl/mem_wb_pipe_reg_if.sv | 39 +++
 rtl/mem_wb_pipe_reg.sv | 151 +++++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_reg_if.sv
// Handshake and data bundle between the MEM stage, the MEM/WB register and the WB consumer.
// slave is the pipeline register's view; master is the surrounding pipeline's view.
interface mem_wb_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_read_data;
    logic [DATA_W-1:0]     in_alu_result;
    logic [REG_ADDR_W-1:0] in_write_reg;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_read_data;
    logic [DATA_W-1:0]     out_alu_result;
    logic [REG_ADDR_W-1:0] out_write_reg;
    logic                  out_reg_write;
    logic                  out_mem_to_reg;
    logic [DATA_W-1:0]     out_wb_data;

    modport master (
        output in_valid, in_read_data, in_alu_result, in_write_reg, in_reg_write, in_mem_to_reg,
        output out_ready,
        input  in_ready,
        input  out_valid, out_read_data, out_alu_result, out_write_reg, out_reg_write,
        input  out_mem_to_reg, out_wb_data
    );

    modport slave (
        input  in_valid, in_read_data, in_alu_result, in_write_reg, in_reg_write, in_mem_to_reg,
        input  out_ready,
        output in_ready,
        output out_valid, out_read_data, out_alu_result, out_write_reg, out_reg_write,
        output out_mem_to_reg, out_wb_data
    );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, synchronous flush and registered writeback mux.
// Define MEM_WB_SKID_EN for a two-entry skid buffer with registered in_ready.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    mem_wb_pipe_reg_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     wb_data;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_to_reg;
    } entry_t;

`ifdef MEM_WB_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
`else
    typedef enum logic [0:0] {EMPTY, ONE} state_t;
`endif

    state_t r_state;
    state_t w_next_state;
    entry_t r_head;
    entry_t w_in_entry;
    logic   w_in_xfer;
    logic   w_out_xfer;
    logic   w_out_valid;
    logic   w_load_head;

`ifdef MEM_WB_SKID_EN
    entry_t r_skid;
    logic   r_in_ready;
    logic   w_load_skid;
    logic   w_head_from_skid;
`endif

    // The writeback mux is resolved at capture so WB sees a register, not a mux.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.read_data  = bus.in_read_data;
        w_in_entry.alu_result = bus.in_alu_result;
        w_in_entry.wb_data    = bus.in_mem_to_reg ? bus.in_read_data : bus.in_alu_result;
        w_in_entry.write_reg  = bus.in_write_reg;
        w_in_entry.reg_write  = bus.in_reg_write;
        w_in_entry.mem_to_reg = bus.in_mem_to_reg;
    end

    assign w_out_valid = (r_state != EMPTY);

`ifdef MEM_WB_SKID_EN
    assign bus.in_ready = r_in_ready || flush;
`else
    assign bus.in_ready = !w_out_valid || bus.out_ready || flush;
`endif

    assign w_in_xfer  = bus.in_valid && bus.in_ready;
    assign w_out_xfer = w_out_valid && bus.out_ready;

    always_comb begin
        w_next_state = r_state;
        w_load_head  = 1'b0;
`ifdef MEM_WB_SKID_EN
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
`endif
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_next_state = ONE;
                        w_load_head  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_head = 1'b1;
                    end else if (w_out_xfer) begin
                        w_next_state = EMPTY;
`ifdef MEM_WB_SKID_EN
                    end else if (w_in_xfer) begin
                        w_next_state = FULL;
                        w_load_skid  = 1'b1;
`endif
                    end
                end
`ifdef MEM_WB_SKID_EN
                FULL: begin
                    if (w_out_xfer) begin
                        w_next_state     = ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
`endif
                default: w_next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_load_head) begin
            r_head <= w_in_entry;
`ifdef MEM_WB_SKID_EN
        end else if (w_head_from_skid) begin
            r_head <= r_skid;
`endif
        end
    end

`ifdef MEM_WB_SKID_EN
    // in_ready is taken from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
            r_in_ready <= (w_next_state != FULL);
        end
    end
`endif

    assign bus.out_valid      = w_out_valid;
    assign bus.out_read_data  = r_head.read_data;
    assign bus.out_alu_result = r_head.alu_result;
    assign bus.out_write_reg  = r_head.write_reg;
    assign bus.out_mem_to_reg = r_head.mem_to_reg;
    assign bus.out_wb_data    = r_head.wb_data;
    assign bus.out_reg_write  = r_head.reg_write && w_out_valid && (r_head.write_reg != '0);

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: directed vectors push expected entries, a monitor pops on each output transfer.
// Skid-specific scenarios follow MEM_WB_SKID_EN.
module tb_mem_wb_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] wb;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    mem_wb_pipe_reg_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

    mem_wb_pipe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    exp_t expQ[$];
    exp_t monAct;
    exp_t monExp;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the oldest expected entry on every output transfer; an output with nothing expected is an error.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            monAct = '{rd: bus.out_read_data, alu: bus.out_alu_result, wb: bus.out_wb_data,
                       wr: bus.out_write_reg, rw: bus.out_reg_write, m2r: bus.out_mem_to_reg};
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected output: actual wb=%0h wr=%0d, required no output", monAct.wb, monAct.wr);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("scoreboard entry", monAct, monExp);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                                 input logic rw, input logic m2r,
                                 input logic [31:0] expWb, input logic expRw, output int cycles);
        exp_t e;
        logic accepted;
        e = '{rd: rd, alu: alu, wb: expWb, wr: wr, rw: expRw, m2r: m2r};
        expQ.push_back(e);
        bus.in_valid      = 1'b1;
        bus.in_read_data  = rd;
        bus.in_alu_result = alu;
        bus.in_write_reg  = wr;
        bus.in_reg_write  = rw;
        bus.in_mem_to_reg = m2r;
        cycles   = 0;
        accepted = 1'b0;
        while (!accepted && cycles < 20) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: actual in_ready=0 after %0d cycles, required 1", cycles);
        end
    endtask

    task automatic driveFlushWithInput(input logic [31:0] rd);
        bus.in_valid      = 1'b1;
        bus.in_read_data  = rd;
        bus.in_alu_result = 32'h0000_00D0;
        bus.in_write_reg  = 5'd13;
        bus.in_reg_write  = 1'b1;
        bus.in_mem_to_reg = 1'b1;
        flush             = 1'b1;
        @(negedge clk);
        checkOutput("in_ready during flush", bus.in_ready, 1);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        expQ.delete();
        checkOutput("out_valid after flush", bus.out_valid, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("drain queue empty", expQ.size(), 0);
    endtask

    initial begin
        int c;
        int sum;
        rst_n             = 1'b1;
        flush             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_read_data  = '0;
        bus.in_alu_result = '0;
        bus.in_write_reg  = '0;
        bus.in_reg_write  = 1'b0;
        bus.in_mem_to_reg = 1'b0;
        bus.out_ready     = 1'b0;

        // Asynchronous reset before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset out_wb_data", bus.out_wb_data, 0);
        checkOutput("reset out_reg_write", bus.out_reg_write, 0);
        checkOutput("reset out_write_reg", bus.out_write_reg, 0);
        checkOutput("reset in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Basic capture, latency and throughput with out_ready high
        bus.out_ready = 1'b1;
        applyStimulus(32'hDEADBEEF, 32'h10, 5'd8, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, c);
        checkOutput("first capture cycles", c, 1);
        checkOutput("latency out_valid", bus.out_valid, 1);
        checkOutput("latency out_wb_data", bus.out_wb_data, 32'hDEADBEEF);
        sum = 0;
        applyStimulus(32'hDEADBEEF, 32'h10, 5'd8, 1'b1, 1'b0, 32'h10, 1'b1, c);
        sum += c;
        applyStimulus(32'h1234, 32'h55, 5'd0, 1'b1, 1'b0, 32'h55, 1'b0, c);
        sum += c;
        checkOutput("r0 out_valid", bus.out_valid, 1);
        checkOutput("r0 out_reg_write", bus.out_reg_write, 0);
        applyStimulus(32'hCAFEF00D, 32'h99, 5'd3, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, c);
        sum += c;
        checkOutput("throughput cycles", sum, 3);
        drain();

        bus.out_ready = 1'b0;
`ifdef MEM_WB_SKID_EN
        // Stall with skid: A on head, B in skid, C waits
        applyStimulus(32'hA0A0A0A0, 32'h1, 5'd1, 1'b1, 1'b1, 32'hA0A0A0A0, 1'b1, c);
        applyStimulus(32'h0B, 32'hB0B0B0B0, 5'd2, 1'b1, 1'b0, 32'hB0B0B0B0, 1'b1, c);
        checkOutput("full in_ready", bus.in_ready, 0);
        checkOutput("full head wb", bus.out_wb_data, 32'hA0A0A0A0);
        fork
            applyStimulus(32'h0C, 32'hCC, 5'd31, 1'b1, 1'b1, 32'h0C, 1'b1, c);
            begin
                repeat (3) tick();
                checkOutput("stall hold wb", bus.out_wb_data, 32'hA0A0A0A0);
                checkOutput("stall hold valid", bus.out_valid, 1);
                checkOutput("stall in_ready", bus.in_ready, 0);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush from FULL with a concurrent input D
        bus.out_ready = 1'b0;
        applyStimulus(32'hE0, 32'hE1, 5'd5, 1'b1, 1'b1, 32'hE0, 1'b1, c);
        applyStimulus(32'hF0, 32'hF1, 5'd6, 1'b1, 1'b0, 32'hF1, 1'b1, c);
        checkOutput("pre-flush in_ready", bus.in_ready, 0);
        driveFlushWithInput(32'hD0D0D0D0);
`else
        // Stall without skid: in_ready follows out_ready combinationally
        applyStimulus(32'hA0A0A0A0, 32'h1, 5'd1, 1'b1, 1'b1, 32'hA0A0A0A0, 1'b1, c);
        checkOutput("stall out_valid", bus.out_valid, 1);
        checkOutput("stall in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("comb in_ready", bus.in_ready, 1);
        applyStimulus(32'h0B, 32'hB0B0B0B0, 5'd2, 1'b1, 1'b0, 32'hB0B0B0B0, 1'b1, c);
        drain();

        // Flush a held entry with a concurrent input D
        bus.out_ready = 1'b0;
        applyStimulus(32'hE0, 32'hE1, 5'd5, 1'b1, 1'b1, 32'hE0, 1'b1, c);
        checkOutput("pre-flush in_ready", bus.in_ready, 0);
        driveFlushWithInput(32'hD0D0D0D0);
`endif
        checkOutput("post-flush in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("flushed stays empty", bus.out_valid, 0);

        // Reset asserted mid-cycle while an entry is held
        bus.out_ready = 1'b0;
        applyStimulus(32'h77, 32'h66, 5'd4, 1'b1, 1'b0, 32'h66, 1'b1, c);
        checkOutput("pre-reset out_valid", bus.out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        expQ.delete();
        checkOutput("mid reset out_valid", bus.out_valid, 0);
        checkOutput("mid reset out_wb_data", bus.out_wb_data, 0);
        checkOutput("mid reset out_reg_write", bus.out_reg_write, 0);
        checkOutput("mid reset in_ready", bus.in_ready, 1);
        #2 rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("queue empty at end", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
